// File: rtl/noise_hit_ctrl.sv
// noise_hit_ctrl: one-shot hit scheduler driving osc_noise with a linear attack/hold/decay envelope
module noise_hit_ctrl #(
  parameter int ATTACK_STEP = 1024
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sample_tick,
  input  logic               trig_valid,
  output logic               trig_ready,
  input  logic [16:0]        trig_period,
  input  logic [14:0]        trig_peak,
  input  logic [15:0]        trig_hold,
  input  logic [15:0]        trig_decay,
  input  logic               kill,
  output logic               osc_en,
  output logic [16:0]        osc_period,
  output logic signed [16:0] osc_volume,
  output logic               busy
);
  typedef enum logic [1:0] {IDLE, ATTACK, HOLD, DECAY} st_t;
  st_t st, st_n;
  logic [14:0] vol, vol_n, pk, pk_n;
  logic [15:0] hc, hc_n, dc, dc_n;
  logic [16:0] per, per_n, sum;
  logic rdy, en, acc;
  assign acc = trig_valid && trig_ready;
  assign sum = {2'b00, vol} + 17'(ATTACK_STEP);
  always_comb begin
    st_n = st;
    vol_n = vol;
    pk_n = pk;
    hc_n = hc;
    dc_n = dc;
    per_n = per;
    if (kill || (acc && trig_peak == '0)) begin
      st_n = IDLE;
      vol_n = '0;
    end else if (acc) begin
      st_n = ATTACK;
      pk_n = trig_peak;
      hc_n = trig_hold;
      dc_n = trig_decay;
      per_n = trig_period;
    end else if (sample_tick) begin
      case (st)
        ATTACK: if (sum >= {2'b00, pk}) begin
          vol_n = pk;
          st_n = hc == '0 ? DECAY : HOLD;
        end else vol_n = sum[14:0];
        HOLD: begin
          hc_n = hc - 16'd1;
          st_n = hc == 16'd1 ? DECAY : HOLD;
        end
        // decay==0 is sustain: the level stays put until kill or retrigger
        DECAY: if (dc != '0) begin
          if ({1'b0, vol} <= dc) begin
            vol_n = '0;
            st_n = IDLE;
          end else vol_n = vol - dc[14:0];
        end
        default: st_n = st;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st <= IDLE;
      vol <= '0;
      pk <= '0;
      hc <= '0;
      dc <= '0;
      per <= '0;
      rdy <= 1'b0;
      en <= 1'b0;
    end else begin
      st <= st_n;
      vol <= vol_n;
      pk <= pk_n;
      hc <= hc_n;
      dc <= dc_n;
      per <= per_n;
      rdy <= st_n == IDLE || st_n == DECAY;
      en <= st_n != IDLE;
    end
  end
  assign trig_ready = rdy && !kill;
  assign osc_en = en;
  assign busy = en;
  assign osc_period = per;
  assign osc_volume = {2'b00, vol};
endmodule

// File: tb/tb_noise_hit_ctrl.sv
// tb_noise_hit_ctrl: directed scenarios for noise_hit_ctrl with hand-computed envelope values
module tb_noise_hit_ctrl;
  logic clk = 0, rst_n = 0, sample_tick = 0, trig_valid = 0, kill = 0;
  logic [16:0] trig_period = '0;
  logic [14:0] trig_peak = '0;
  logic [15:0] trig_hold = '0, trig_decay = '0;
  logic trig_ready, osc_en, busy;
  logic [16:0] osc_period;
  logic signed [16:0] osc_volume;
  int errs = 0, checks = 0;

  noise_hit_ctrl #(.ATTACK_STEP(1024)) dut (
    .clk(clk), .rst_n(rst_n), .sample_tick(sample_tick), .trig_valid(trig_valid),
    .trig_ready(trig_ready), .trig_period(trig_period), .trig_peak(trig_peak),
    .trig_hold(trig_hold), .trig_decay(trig_decay), .kill(kill), .osc_en(osc_en),
    .osc_period(osc_period), .osc_volume(osc_volume), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    sample_tick = 1;
    cyc();
    sample_tick = 0;
  endtask

  task automatic hit(input int p, input int pk, input int h, input int d);
    trig_valid = 1;
    trig_period = 17'(p);
    trig_peak = 15'(pk);
    trig_hold = 16'(h);
    trig_decay = 16'(d);
    cyc();
    trig_valid = 0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (3) cyc();
    checks++; if (osc_en !== 0 || busy !== 0) begin errs++; $display("FAIL reset_en: osc_en=%b busy=%b want 0 0", osc_en, busy); end
    checks++; if (osc_volume !== 17'sd0 || osc_period !== 17'd0) begin errs++; $display("FAIL reset_out: vol=%0d period=%0d want 0 0", osc_volume, osc_period); end
    checks++; if (trig_ready !== 0) begin errs++; $display("FAIL reset_ready_low: ready=%b want 0", trig_ready); end
    rst_n = 1;
    cyc();
    checks++; if (trig_ready !== 1) begin errs++; $display("FAIL reset_ready_rel: ready=%b want 1", trig_ready); end
  endtask

  task automatic test_basic();
    hit(100, 4096, 2, 512);
    checks++; if (osc_en !== 1 || osc_period !== 17'd100 || trig_ready !== 0 || busy !== 1) begin errs++; $display("FAIL basic_accept: en=%b period=%0d ready=%b busy=%b want 1 100 0 1", osc_en, osc_period, trig_ready, busy); end
    checks++; if (osc_volume !== 17'sd0) begin errs++; $display("FAIL basic_start: vol=%0d want 0", osc_volume); end
    cyc();
    checks++; if (osc_volume !== 17'sd0) begin errs++; $display("FAIL basic_notick: vol=%0d want 0", osc_volume); end
    for (int i = 1; i <= 4; i++) begin
      tick();
      checks++; if (osc_volume !== 17'(1024 * i)) begin errs++; $display("FAIL basic_attack: vol=%0d want %0d", osc_volume, 1024 * i); end
    end
    for (int i = 0; i < 2; i++) begin
      checks++; if (trig_ready !== 0) begin errs++; $display("FAIL basic_hold_ready: ready=%b want 0", trig_ready); end
      tick();
      checks++; if (osc_volume !== 17'sd4096) begin errs++; $display("FAIL basic_hold: vol=%0d want 4096", osc_volume); end
    end
    checks++; if (trig_ready !== 1) begin errs++; $display("FAIL basic_decay_ready: ready=%b want 1", trig_ready); end
    for (int i = 1; i <= 8; i++) begin
      tick();
      checks++; if (osc_volume !== 17'(4096 - 512 * i)) begin errs++; $display("FAIL basic_decay: vol=%0d want %0d", osc_volume, 4096 - 512 * i); end
    end
    checks++; if (osc_en !== 0 || busy !== 0 || trig_ready !== 1) begin errs++; $display("FAIL basic_idle: en=%b busy=%b ready=%b want 0 0 1", osc_en, busy, trig_ready); end
    checks++; if (osc_period !== 17'd100) begin errs++; $display("FAIL basic_period_hold: period=%0d want 100", osc_period); end
    tick();
    checks++; if (osc_volume !== 17'sd0 || osc_en !== 0) begin errs++; $display("FAIL idle_tick: vol=%0d en=%b want 0 0", osc_volume, osc_en); end
  endtask

  task automatic test_retrigger();
    hit(200, 4096, 0, 1024);
    repeat (6) tick();
    checks++; if (osc_volume !== 17'sd2048 || trig_ready !== 1) begin errs++; $display("FAIL retrig_pre: vol=%0d ready=%b want 2048 1", osc_volume, trig_ready); end
    sample_tick = 1;
    hit(300, 3000, 0, 40000);
    sample_tick = 0;
    checks++; if (osc_volume !== 17'sd2048 || osc_period !== 17'd300) begin errs++; $display("FAIL retrig_accept: vol=%0d period=%0d want 2048 300", osc_volume, osc_period); end
    tick();
    checks++; if (osc_volume !== 17'sd3000) begin errs++; $display("FAIL retrig_clamp: vol=%0d want 3000", osc_volume); end
    tick();
    checks++; if (osc_volume !== 17'sd0 || osc_en !== 0) begin errs++; $display("FAIL big_decay: vol=%0d en=%b want 0 0", osc_volume, osc_en); end
  endtask

  task automatic test_back_to_back();
    hit(111, 2048, 1, 1000);
    trig_valid = 1;
    trig_period = 17'd222;
    trig_peak = 15'd1500;
    trig_hold = 16'd0;
    trig_decay = 16'd0;
    for (int i = 1; i <= 3; i++) begin
      checks++; if (trig_ready !== 0) begin errs++; $display("FAIL bp_ready: ready=%b want 0", trig_ready); end
      tick();
    end
    checks++; if (osc_volume !== 17'sd2048 || osc_period !== 17'd111 || trig_ready !== 1) begin errs++; $display("FAIL bp_first_decay: vol=%0d period=%0d ready=%b want 2048 111 1", osc_volume, osc_period, trig_ready); end
    cyc();
    trig_valid = 0;
    checks++; if (osc_period !== 17'd222 || trig_ready !== 0) begin errs++; $display("FAIL bp_accept: period=%0d ready=%b want 222 0", osc_period, trig_ready); end
    tick();
    checks++; if (osc_volume !== 17'sd1500) begin errs++; $display("FAIL bp_clamp: vol=%0d want 1500", osc_volume); end
    repeat (1000) tick();
    checks++; if (osc_volume !== 17'sd1500 || busy !== 1) begin errs++; $display("FAIL sustain: vol=%0d busy=%b want 1500 1", osc_volume, busy); end
  endtask

  task automatic test_kill();
    hit(50, 1024, 5, 100);
    tick();
    checks++; if (osc_volume !== 17'sd1024 || trig_ready !== 0) begin errs++; $display("FAIL kill_hold_entry: vol=%0d ready=%b want 1024 0", osc_volume, trig_ready); end
    kill = 1;
    sample_tick = 1;
    trig_valid = 1;
    trig_period = 17'd77;
    trig_peak = 15'd5000;
    #1;
    checks++; if (trig_ready !== 0) begin errs++; $display("FAIL kill_ready: ready=%b want 0", trig_ready); end
    cyc();
    kill = 0;
    sample_tick = 0;
    trig_valid = 0;
    checks++; if (osc_en !== 0 || busy !== 0 || osc_volume !== 17'sd0) begin errs++; $display("FAIL kill_idle: en=%b busy=%b vol=%0d want 0 0 0", osc_en, busy, osc_volume); end
    checks++; if (osc_period !== 17'd50) begin errs++; $display("FAIL kill_noaccept: period=%0d want 50", osc_period); end
  endtask

  task automatic test_peak_zero();
    hit(999, 0, 3, 3);
    checks++; if (osc_en !== 0 || busy !== 0 || trig_ready !== 1 || osc_volume !== 17'sd0) begin errs++; $display("FAIL peak_zero: en=%b busy=%b ready=%b vol=%0d want 0 0 1 0", osc_en, busy, trig_ready, osc_volume); end
  endtask

  task automatic test_reset_mid();
    hit(100, 4096, 0, 512);
    repeat (5) tick();
    checks++; if (osc_volume !== 17'sd3584 || busy !== 1) begin errs++; $display("FAIL mid_pre: vol=%0d busy=%b want 3584 1", osc_volume, busy); end
    rst_n = 0;
    sample_tick = 1;
    cyc();
    checks++; if (osc_en !== 0 || busy !== 0 || osc_volume !== 17'sd0 || osc_period !== 17'd0) begin errs++; $display("FAIL mid_reset: en=%b busy=%b vol=%0d period=%0d want 0 0 0 0", osc_en, busy, osc_volume, osc_period); end
    repeat (2) cyc();
    sample_tick = 0;
    checks++; if (trig_ready !== 0) begin errs++; $display("FAIL mid_ready_low: ready=%b want 0", trig_ready); end
    rst_n = 1;
    cyc();
    checks++; if (trig_ready !== 1 || busy !== 0 || osc_volume !== 17'sd0) begin errs++; $display("FAIL mid_release: ready=%b busy=%b vol=%0d want 1 0 0", trig_ready, busy, osc_volume); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_retrigger();
    test_back_to_back();
    test_kill();
    test_peak_zero();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
